fetch_queue: RTL and testbench

Parametrised fetch stage for the pipelined core generation. It replaces the single-cycle fetch of the pd3 datapath.
- Generates sequential PCs and issues reads to an instruction memory with fixed multi-cycle latency.
- Buffers returned instructions with their PCs in an in-order queue.
- Hands instructions to decode over a valid/ready handshake.
- Flushes everything on a branch/jump redirect from execute.

---
 rtl/fetch_queue_if.sv | 30 +++
 rtl/fetch_queue.sv | 136 +++++++++++++
 tb/tb_fetch_queue.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory, execute
// (redirect) and decode. The master side is the fetch queue itself.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             imem_req;
  logic [XLEN-1:0]  imem_addr;
  logic [ILEN-1:0]  imem_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [ILEN-1:0]  out_insn;
  logic [OCC_W-1:0] occupancy;

  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_pc, out_insn, occupancy
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_pc, out_insn, occupancy
  );
endinterface

// File: rtl/fetch_queue.sv
// Pipelined fetch stage: sequential PC generation, fixed-latency imem reads
// tracked per stage, in-order instruction queue toward decode, redirect flush.
module fetch_queue #(
  parameter int              XLEN        = 32,
  parameter int              ILEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(32'h0100_0000),
  parameter int              DEPTH       = 4,
  parameter int              MEM_LATENCY = 1
) (
  input logic         clock,
  input logic         reset,
  fetch_queue_if.master bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0]        fetch_pc;
  logic [MEM_LATENCY-1:0] vld_p;
  logic [MEM_LATENCY-1:0] vld_p_nxt;
  logic [XLEN-1:0]        pc_p [MEM_LATENCY];

  logic [XLEN-1:0]        q_pc   [DEPTH];
  logic [ILEN-1:0]        q_insn [DEPTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [OCC_W-1:0]       count, count_nxt;
  logic [XLEN-1:0]        head_pc, head_pc_nxt;
  logic [ILEN-1:0]        head_insn, head_insn_nxt;

  logic                   issue;
  logic                   push;
  logic                   pop;
  int                     inflight;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Credit check uses start-of-cycle occupancy; a same-cycle pop earns nothing.
  always_comb begin
    inflight = $countones(vld_p);
  end

  assign issue = !reset && !bus.redirect_valid && ((int'(count) + inflight) < DEPTH);
  assign push  = vld_p[MEM_LATENCY-1] && !bus.redirect_valid;
  assign pop   = (count != '0) && bus.out_ready;

  always_comb begin
    vld_p_nxt    = '0;
    vld_p_nxt[0] = issue;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      vld_p_nxt[i] = vld_p[i-1] && !bus.redirect_valid;
    end
  end

  always_comb begin
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count;
    if (bus.redirect_valid) begin
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push) wr_ptr_nxt = ptr_inc(wr_ptr);
      if (pop)  rd_ptr_nxt = ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end
  end

  // Registered head: when the only remaining entry is the one being pushed,
  // take it from the response directly; an empty queue keeps the old value.
  always_comb begin
    head_pc_nxt   = head_pc;
    head_insn_nxt = head_insn;
    if (count_nxt != '0) begin
      if (push && (count_nxt == OCC_W'(1))) begin
        head_pc_nxt   = pc_p[MEM_LATENCY-1];
        head_insn_nxt = bus.imem_rdata;
      end else begin
        head_pc_nxt   = q_pc[rd_ptr_nxt];
        head_insn_nxt = q_insn[rd_ptr_nxt];
      end
    end
  end

  // Control state
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      vld_p     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      head_pc   <= '0;
      head_insn <= '0;
    end else begin
      if (bus.redirect_valid) begin
        fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      end else if (issue) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      vld_p     <= vld_p_nxt;
      rd_ptr    <= rd_ptr_nxt;
      wr_ptr    <= wr_ptr_nxt;
      count     <= count_nxt;
      head_pc   <= head_pc_nxt;
      head_insn <= head_insn_nxt;
    end
  end

  // Tracker PCs and queue storage
  always_ff @(posedge clock) begin
    pc_p[0] <= fetch_pc;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      pc_p[i] <= pc_p[i-1];
    end
    if (push) begin
      q_pc[wr_ptr]   <= pc_p[MEM_LATENCY-1];
      q_insn[wr_ptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc;
  assign bus.out_valid = (count != '0);
  assign bus.out_pc    = head_pc;
  assign bus.out_insn  = head_insn;
  assign bus.occupancy = count;

  push_not_full: assert property (@(posedge clock) disable iff (reset)
    !(push && (count == OCC_W'(DEPTH))));
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: latency-1/depth-4 and latency-3/depth-5 instances.
module tb_fetch_queue;
  logic clock;
  logic reset_a;
  logic reset_b;
  int   checks;
  int   errors;

  localparam logic [31:0] RPC = 32'h0100_0000;

  fetch_queue_if #(.XLEN(32), .ILEN(32), .DEPTH(4)) ifa ();
  fetch_queue_if #(.XLEN(32), .ILEN(32), .DEPTH(5)) ifb ();

  fetch_queue #(.XLEN(32), .ILEN(32), .RESET_PC(RPC), .DEPTH(4), .MEM_LATENCY(1)) dut_a (
    .clock(clock), .reset(reset_a), .bus(ifa));
  fetch_queue #(.XLEN(32), .ILEN(32), .RESET_PC(RPC), .DEPTH(5), .MEM_LATENCY(3)) dut_b (
    .clock(clock), .reset(reset_b), .bus(ifb));

  // Instruction memory models: insn = addr, returned after the configured latency
  logic [31:0] mem_a_q;
  logic [31:0] mem_b_q [3];
  always @(posedge clock) begin
    mem_a_q    <= ifa.imem_addr;
    mem_b_q[0] <= ifb.imem_addr;
    mem_b_q[1] <= mem_b_q[0];
    mem_b_q[2] <= mem_b_q[1];
  end
  assign ifa.imem_rdata = mem_a_q;
  assign ifb.imem_rdata = mem_b_q[2];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_a(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clock);
    reset_a            = rst;
    ifa.out_ready      = rdy;
    ifa.redirect_valid = rv;
    ifa.redirect_pc    = rpc;
    #1;
  endtask

  task automatic cyc_b(input logic rst, input logic rdy);
    @(negedge clock);
    reset_b       = rst;
    ifb.out_ready = rdy;
    #1;
  endtask

  task automatic fill_a_to_occ3();
    cyc_a(1'b1, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 4; c++) cyc_a(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  logic [31:0] exp_pc;

  initial begin
    checks = 0;
    errors = 0;
    reset_a = 1'b1;
    reset_b = 1'b1;
    ifa.out_ready = 1'b1; ifa.redirect_valid = 1'b0; ifa.redirect_pc = 32'h0;
    ifb.out_ready = 1'b1; ifb.redirect_valid = 1'b0; ifb.redirect_pc = 32'h0;

    // Reset state
    cyc_a(1'b1, 1'b1, 1'b0, 32'h0);
    cyc_a(1'b1, 1'b1, 1'b0, 32'h0);
    check("rst_req",   32'(ifa.imem_req),  32'd0);
    check("rst_valid", 32'(ifa.out_valid), 32'd0);
    check("rst_occ",   32'(ifa.occupancy), 32'd0);
    check("rst_addr",  ifa.imem_addr,      RPC);
    check("rst_pc",    ifa.out_pc,         32'd0);
    check("rst_insn",  ifa.out_insn,       32'd0);

    // Streaming with latency 1
    cyc_a(1'b0, 1'b1, 1'b0, 32'h0);
    check("t1_c0_req",   32'(ifa.imem_req),  32'd1);
    check("t1_c0_addr",  ifa.imem_addr,      RPC);
    check("t1_c0_valid", 32'(ifa.out_valid), 32'd0);
    cyc_a(1'b0, 1'b1, 1'b0, 32'h0);
    check("t1_c1_valid", 32'(ifa.out_valid), 32'd0);
    check("t1_c1_addr",  ifa.imem_addr,      RPC + 32'd4);
    for (int k = 0; k < 3; k++) begin
      cyc_a(1'b0, 1'b1, 1'b0, 32'h0);
      check("t1_valid", 32'(ifa.out_valid), 32'd1);
      check("t1_pc",    ifa.out_pc,         RPC + 32'(4 * k));
      check("t1_insn",  ifa.out_insn,       RPC + 32'(4 * k));
    end

    // Back-pressure: queue saturates, then drains in order
    cyc_a(1'b1, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 10; c++) begin
      cyc_a(1'b0, 1'b0, 1'b0, 32'h0);
      if (c == 4) begin
        check("t2_c4_req", 32'(ifa.imem_req),  32'd0);
        check("t2_c4_occ", 32'(ifa.occupancy), 32'd3);
      end
      if (c >= 5) begin
        check("t2_sat_occ", 32'(ifa.occupancy), 32'd4);
        check("t2_sat_req", 32'(ifa.imem_req),  32'd0);
        check("t2_sat_pc",  ifa.out_pc,         RPC);
      end
    end
    for (int k = 0; k < 7; k++) begin
      cyc_a(1'b0, 1'b1, 1'b0, 32'h0);
      if (k == 0) check("t2_nocredit_req", 32'(ifa.imem_req), 32'd0);
      if (k == 1) begin
        check("t2_resume_req",  32'(ifa.imem_req), 32'd1);
        check("t2_resume_addr", ifa.imem_addr,     RPC + 32'h10);
      end
      check("t2_valid", 32'(ifa.out_valid), 32'd1);
      check("t2_pc",    ifa.out_pc,         RPC + 32'(4 * k));
    end

    // Redirect with occupancy 3 and one response in flight
    fill_a_to_occ3();
    cyc_a(1'b0, 1'b0, 1'b1, 32'h0100_0100);
    check("t3_redir_req",   32'(ifa.imem_req),  32'd0);
    check("t3_redir_valid", 32'(ifa.out_valid), 32'd1);
    check("t3_redir_pc",    ifa.out_pc,         RPC);
    check("t3_redir_occ",   32'(ifa.occupancy), 32'd3);
    cyc_a(1'b0, 1'b1, 1'b0, 32'h0);
    check("t3_post_occ",   32'(ifa.occupancy), 32'd0);
    check("t3_post_valid", 32'(ifa.out_valid), 32'd0);
    check("t3_post_addr",  ifa.imem_addr,      32'h0100_0100);
    check("t3_post_req",   32'(ifa.imem_req),  32'd1);
    cyc_a(1'b0, 1'b1, 1'b0, 32'h0);
    check("t3_nostale_valid", 32'(ifa.out_valid), 32'd0);
    for (int k = 0; k < 2; k++) begin
      cyc_a(1'b0, 1'b1, 1'b0, 32'h0);
      check("t3_valid", 32'(ifa.out_valid), 32'd1);
      check("t3_pc",    ifa.out_pc,         32'h0100_0100 + 32'(4 * k));
      check("t3_insn",  ifa.out_insn,       32'h0100_0100 + 32'(4 * k));
    end

    // Back-to-back redirects: misaligned target, then the winner
    cyc_a(1'b0, 1'b1, 1'b1, 32'h0100_0102);
    check("t4_r1_req", 32'(ifa.imem_req), 32'd0);
    cyc_a(1'b0, 1'b1, 1'b1, 32'h0100_0200);
    check("t4_r2_req",  32'(ifa.imem_req),  32'd0);
    check("t4_r2_addr", ifa.imem_addr,      32'h0100_0100);
    check("t4_r2_occ",  32'(ifa.occupancy), 32'd0);
    cyc_a(1'b0, 1'b1, 1'b0, 32'h0);
    check("t4_addr",  ifa.imem_addr,      32'h0100_0200);
    check("t4_req",   32'(ifa.imem_req),  32'd1);
    check("t4_valid0", 32'(ifa.out_valid), 32'd0);
    cyc_a(1'b0, 1'b1, 1'b0, 32'h0);
    check("t4_valid1", 32'(ifa.out_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc_a(1'b0, 1'b1, 1'b0, 32'h0);
      check("t4_valid", 32'(ifa.out_valid), 32'd1);
      check("t4_pc",    ifa.out_pc,         32'h0100_0200 + 32'(4 * k));
    end

    // Mid-operation reset discards queued and in-flight work
    fill_a_to_occ3();
    cyc_a(1'b1, 1'b0, 1'b0, 32'h0);
    check("t5_rst_occ", 32'(ifa.occupancy), 32'd3);
    check("t5_rst_req", 32'(ifa.imem_req),  32'd0);
    cyc_a(1'b0, 1'b1, 1'b0, 32'h0);
    check("t5_occ",   32'(ifa.occupancy), 32'd0);
    check("t5_valid", 32'(ifa.out_valid), 32'd0);
    check("t5_addr",  ifa.imem_addr,      RPC);
    check("t5_req",   32'(ifa.imem_req),  32'd1);
    check("t5_pc",    ifa.out_pc,         32'd0);
    cyc_a(1'b0, 1'b1, 1'b0, 32'h0);
    check("t5_nostale_valid", 32'(ifa.out_valid), 32'd0);
    for (int k = 0; k < 2; k++) begin
      cyc_a(1'b0, 1'b1, 1'b0, 32'h0);
      check("t5_valid2", 32'(ifa.out_valid), 32'd1);
      check("t5_pc2",    ifa.out_pc,         RPC + 32'(4 * k));
    end

    // Latency 3, depth 5: fill then sustained one per cycle
    cyc_b(1'b1, 1'b1);
    cyc_b(1'b1, 1'b1);
    check("t6_rst_occ",  32'(ifb.occupancy), 32'd0);
    check("t6_rst_addr", ifb.imem_addr,      RPC);
    for (int c = 0; c < 20; c++) begin
      cyc_b(1'b0, 1'b1);
      if (c == 0) check("t6_c0_req", 32'(ifb.imem_req), 32'd1);
      if (c == 3) check("t6_c3_valid", 32'(ifb.out_valid), 32'd0);
      if (c >= 4) begin
        check("t6_valid", 32'(ifb.out_valid), 32'd1);
        check("t6_pc",    ifb.out_pc,         RPC + 32'(4 * (c - 4)));
        check("t6_insn",  ifb.out_insn,       RPC + 32'(4 * (c - 4)));
      end
    end
    exp_pc = RPC + 32'h40;
    for (int c = 0; c < 24; c++) begin
      cyc_b(1'b0, ((c % 2) == 0));
      check("t6_occ_le5", 32'(ifb.occupancy <= 5), 32'd1);
      if (ifb.out_valid && ifb.out_ready) begin
        check("t6_order_pc",   ifb.out_pc,   exp_pc);
        check("t6_order_insn", ifb.out_insn, exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
    end
    check("t6_progress", 32'(exp_pc >= RPC + 32'h40 + 32'd40), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
